// File: rtl/regfile_write_ctrl.sv
// Single write-port controller for the 32-entry register file: clears x1..x(N-1)
// after reset, then round-robin arbitrates ALU (A) and load (B) writebacks.
module regfile_write_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [ADDR_WIDTH-1:0] a_id,
    input  logic [DATA_WIDTH-1:0] a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [ADDR_WIDTH-1:0] b_id,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  b_ready,
    output logic                  rf_write_en,
    output logic [ADDR_WIDTH-1:0] rf_write_id,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    output logic                  init_done
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] FIRST_ID = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ID  = '1;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ID  = '0;

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    ptr_q;      // 0: A holds priority, 1: B holds priority
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_id_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;
    logic                    init_done_q;

    logic                    a_acc_s;
    logic                    b_acc_s;
    logic                    wr_take_d;
    logic [ADDR_WIDTH-1:0]   wr_id_d;
    logic [DATA_WIDTH-1:0]   wr_data_d;

    // Ready generation: idle cycles park ready on the priority side
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (state_q == RUN) begin
            if (a_valid && b_valid) begin
                a_ready = ~ptr_q;
                b_ready = ptr_q;
            end else if (a_valid) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end else begin
                a_ready = ~ptr_q;
                b_ready = ptr_q;
            end
        end else begin
            a_ready = 1'b0;
            b_ready = 1'b0;
        end
    end

    assign a_acc_s = a_valid & a_ready;
    assign b_acc_s = b_valid & b_ready;

    // Select the accepted write; an id-0 write is consumed without a port write
    always_comb begin
        wr_take_d = 1'b0;
        wr_id_d   = a_id;
        wr_data_d = a_data;
        if (a_acc_s) begin
            wr_take_d = (a_id != ZERO_ID);
            wr_id_d   = a_id;
            wr_data_d = a_data;
        end else if (b_acc_s) begin
            wr_take_d = (b_id != ZERO_ID);
            wr_id_d   = b_id;
            wr_data_d = b_data;
        end else begin
            wr_take_d = 1'b0;
        end
    end

    // Controller FSM with registered write-port outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= FIRST_ID;
            ptr_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_id_q     <= '0;
            wr_data_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    wr_en_q   <= 1'b1;
                    wr_id_q   <= cnt_q;
                    wr_data_q <= '0;
                    cnt_q     <= cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LAST_ID) begin
                        state_q     <= RUN;
                        init_done_q <= 1'b1;
                    end
                end
                RUN: begin
                    wr_en_q <= wr_take_d;
                    if (wr_take_d) begin
                        wr_id_q   <= wr_id_d;
                        wr_data_q <= wr_data_d;
                    end
                    // Contested grant hands priority to the loser
                    if (a_valid && b_valid) begin
                        ptr_q <= ~ptr_q;
                    end
                end
                default: begin
                    state_q <= INIT;
                    wr_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign rf_write_en   = wr_en_q;
    assign rf_write_id   = wr_id_q;
    assign rf_write_data = wr_data_q;
    assign init_done     = init_done_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: driver predicts readies and queues
// expected writes (tagged with their edge); a monitor pops on each port write.
module tb_regfile_write_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_valid = 1'b0, b_valid = 1'b0;
    logic [AW-1:0] a_id = '0, b_id = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, rf_write_en, init_done;
    logic [AW-1:0] rf_write_id;
    logic [DW-1:0] rf_write_data;

    regfile_write_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_id(a_id), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_id(b_id), .b_data(b_data), .b_ready(b_ready),
        .rf_write_en(rf_write_en), .rf_write_id(rf_write_id),
        .rf_write_data(rf_write_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            edge_no;
        logic [AW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          q[$];
    int            checks = 0;
    int            errors = 0;
    int            edge_n = 0;
    logic [AW-1:0] last_id = '0;
    logic [DW-1:0] last_data = '0;

    // Requester state and reference arbitration pointer (0 = A next on contention)
    bit            pend_a = 1'b0, pend_b = 1'b0;
    logic [AW-1:0] id_a = '0, id_b = '0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    bit            prio_b = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_clear();
        for (int i = 1; i < NREG; i++) begin
            exp_t e;
            e.edge_no = i;
            e.id      = AW'(i);
            e.data    = '0;
            q.push_back(e);
        end
    endtask

    // One cycle of stimulus; pa/pb are percent chances of a new request
    task automatic step(input int pa, input int pb);
        bit run, exp_ar, exp_br, both;
        exp_t e;
        @(negedge clk);
        if (!pend_a && $urandom_range(0, 99) < pa) begin
            pend_a = 1'b1; id_a = AW'($urandom); data_a = $urandom;
        end
        if (!pend_b && $urandom_range(0, 99) < pb) begin
            pend_b = 1'b1; id_b = AW'($urandom); data_b = $urandom;
        end
        a_valid = pend_a; a_id = id_a; a_data = data_a;
        b_valid = pend_b; b_id = id_b; b_data = data_b;
        #1;
        run = (edge_n >= NREG - 1);
        both = pend_a && pend_b;
        exp_ar = 1'b0;
        exp_br = 1'b0;
        if (run) begin
            if (pend_a && !pend_b)      exp_ar = 1'b1;
            else if (pend_b && !pend_a) exp_br = 1'b1;
            else begin
                exp_ar = !prio_b;
                exp_br = prio_b;
            end
        end
        chk("a_ready", a_ready, exp_ar);
        chk("b_ready", b_ready, exp_br);
        e.edge_no = edge_n + 1;
        if (exp_ar && pend_a) begin
            e.id = id_a; e.data = data_a;
            if (id_a != '0) q.push_back(e);
            pend_a = 1'b0;
        end else if (exp_br && pend_b) begin
            e.id = id_b; e.data = data_b;
            if (id_b != '0) q.push_back(e);
            pend_b = 1'b0;
        end
        if (run && both) prio_b = !prio_b;
    endtask

    // Monitor: checks outputs after every rising edge and pops on each write
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                edge_n = 0;
                chk("rst_en", rf_write_en, 1'b0);
                chk("rst_id", rf_write_id, '0);
                chk("rst_data", rf_write_data, '0);
                chk("rst_init_done", init_done, 1'b0);
            end else begin
                edge_n++;
                chk("init_done", init_done, (edge_n >= NREG - 1) ? 1'b1 : 1'b0);
                if (rf_write_en) begin
                    if (q.size() == 0) begin
                        chk("spurious_write_id", rf_write_id, '1);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("write_edge", edge_n, e.edge_no);
                        chk("write_id", rf_write_id, e.id);
                        chk("write_data", rf_write_data, e.data);
                        last_id   = e.id;
                        last_data = e.data;
                    end
                end else begin
                    if (q.size() != 0 && q[0].edge_no <= edge_n)
                        chk("missing_write_edge", edge_n, q[0].edge_no + 1);
                    chk("hold_id", rf_write_id, last_id);
                    chk("hold_data", rf_write_data, last_data);
                end
            end
        end
    end

    initial begin
        // Reset release with an A request raised mid-clear
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_clear();
        repeat (9) step(0, 0);
        pend_a = 1'b1; id_a = 5'd7; data_a = 32'hA5A5_0007;
        repeat (25) step(0, 0);
        repeat (3) step(0, 0);

        // Lone A write
        pend_a = 1'b1; id_a = 5'd5; data_a = 32'hDEAD_BEEF;
        step(0, 0);
        step(0, 0);

        // Four cycles of contention, ids 1 and 2
        for (int i = 0; i < 4; i++) begin
            if (!pend_a) begin pend_a = 1'b1; id_a = 5'd1; data_a = 32'h1111_0000 + i; end
            if (!pend_b) begin pend_b = 1'b1; id_b = 5'd2; data_b = 32'h2222_0000 + i; end
            step(0, 0);
        end
        repeat (3) step(0, 0);

        // B write to x0 is consumed without a port write
        pend_b = 1'b1; id_b = 5'd0; data_b = 32'h0000_1234;
        step(0, 0);
        repeat (2) step(0, 0);

        // Random traffic with a reset pulse while A is streaming
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                pend_a = 1'b1; id_a = 5'd9; data_a = 32'hCAFE_0009;
                step(0, 30);
                #2;
                rst = 1'b1;
                #1;
                chk("async_rst_en", rf_write_en, 1'b0);
                chk("async_rst_init_done", init_done, 1'b0);
                chk("async_rst_a_ready", a_ready, 1'b0);
                chk("async_rst_b_ready", b_ready, 1'b0);
                q.delete();
                last_id   = '0;
                last_data = '0;
                prio_b    = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                push_clear();
            end else begin
                step(60, 60);
            end
        end
        repeat (5) step(0, 0);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
